// File: rtl/mcpu_program_loader_if.sv
// rtl/mcpu_program_loader_if.sv - byte stream in and RAM write port out of the program loader
// master is the host/bench side, slave is the loader.
interface mcpu_program_loader_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8
);
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mcpu_program_loader.sv
// rtl/mcpu_program_loader.sv - framed byte-stream loader writing big-endian words into MCPU RAM
// Frame: LEN, 2*LEN payload bytes (high byte first), CSUM = XOR of LEN and payload.
module mcpu_program_loader #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8,
  parameter int LOAD_BASE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  mcpu_program_loader_if.slave  bus,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_SIZE-1:0] BASE = ADDR_SIZE'(LOAD_BASE);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t               state, state_nxt;
  logic [7:0]           cnt;
  logic [7:0]           csum;
  logic [7:0]           hi;
  logic [ADDR_SIZE-1:0] addr;
  logic [WORD_SIZE-1:0] wdata;
  logic                 ready;
  logic                 accept;

  assign ready  = (state == S_LEN) || (state == S_HI) ||
                  (state == S_LO)  || (state == S_CSUM);
  assign accept = ready && bus.rx_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_LEN;
      S_LEN:   if (accept) state_nxt = (bus.rx_data == 8'd0) ? S_CSUM : S_HI;
      S_HI:    if (accept) state_nxt = S_LO;
      S_LO:    if (accept) state_nxt = S_WRITE;
      S_WRITE: state_nxt = (cnt == 8'd1) ? S_CSUM : S_HI;
      S_CSUM:  if (accept) state_nxt = (bus.rx_data == csum) ? S_DONE : S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Word count, checksum and write address/data; mem_addr/mem_wdata only move when a word is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= 8'd0;
      csum  <= 8'd0;
      hi    <= 8'd0;
      addr  <= BASE;
      wdata <= '0;
    end else begin
      unique case (state)
        S_LEN: if (accept) begin
          cnt  <= bus.rx_data;
          csum <= bus.rx_data;
          addr <= BASE;
        end
        S_HI: if (accept) begin
          hi   <= bus.rx_data;
          csum <= csum ^ bus.rx_data;
        end
        S_LO: if (accept) begin
          wdata <= WORD_SIZE'({hi, bus.rx_data});
          csum  <= csum ^ bus.rx_data;
        end
        S_WRITE: begin
          addr <= addr + 1'b1;
          cnt  <= cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_ready  = ready;
  assign bus.mem_we    = (state == S_WRITE);
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;

  assign cpu_hold = (state != S_DONE);
  assign busy     = ready || (state == S_WRITE);
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERR);

endmodule

// File: tb/tb_mcpu_program_loader.sv
// tb/tb_mcpu_program_loader.sv - randomized frame bench for mcpu_program_loader
// Two loaders (base 0 and base 254) share one byte stream; writes are compared against frame-derived words.
module tb_mcpu_program_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;

  always #5 clk = ~clk;

  mcpu_program_loader_if #(.WORD_SIZE(16), .ADDR_SIZE(8)) bus0 ();
  mcpu_program_loader_if #(.WORD_SIZE(16), .ADDR_SIZE(8)) bus1 ();

  assign bus0.rx_data  = rx_data;
  assign bus0.rx_valid = rx_valid;
  assign bus1.rx_data  = rx_data;
  assign bus1.rx_valid = rx_valid;

  logic hold0, busy0, done0, err0;
  logic hold1, busy1, done1, err1;

  mcpu_program_loader #(.WORD_SIZE(16), .ADDR_SIZE(8), .LOAD_BASE(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .bus(bus0.slave),
    .cpu_hold(hold0), .busy(busy0), .done(done0), .error(err0)
  );

  mcpu_program_loader #(.WORD_SIZE(16), .ADDR_SIZE(8), .LOAD_BASE(254)) dut1 (
    .clk(clk), .reset(reset), .start(start), .bus(bus1.slave),
    .cpu_hold(hold1), .busy(busy1), .done(done1), .error(err1)
  );

  int total = 0;
  int bad = 0;

  logic [23:0] obs0[$];
  logic [23:0] obs1[$];
  logic [15:0] mem0[256];
  logic [15:0] mem1[256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM model: captures every write the loaders issue.
  always @(negedge clk) begin
    if (bus0.mem_we === 1'b1) begin
      check("ready_low_in_write", {31'd0, bus0.rx_ready}, 32'd0);
      obs0.push_back({bus0.mem_addr, bus0.mem_wdata});
      mem0[bus0.mem_addr] = bus0.mem_wdata;
    end
    if (bus1.mem_we === 1'b1) begin
      obs1.push_back({bus1.mem_addr, bus1.mem_wdata});
      mem1[bus1.mem_addr] = bus1.mem_wdata;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus0.rx_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("byte_accepted", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Idle cycles on the stream; start is pulsed randomly while the loader is busy and must be ignored.
  task automatic gap(input int k);
    for (int i = 0; i < k; i++) begin
      if ($urandom_range(0, 1) == 1) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [15:0] w[$], input logic [7:0] flip, input int maxgap);
    logic [7:0] n;
    logic [7:0] csum;
    logic [7:0] bytes[$];
    bit good;
    n    = 8'(w.size());
    csum = n;
    bytes.push_back(n);
    foreach (w[i]) begin
      bytes.push_back(w[i][15:8]);
      bytes.push_back(w[i][7:0]);
      csum = csum ^ w[i][15:8] ^ w[i][7:0];
    end
    bytes.push_back(csum ^ flip);
    good = (flip == 8'd0);
    obs0.delete();
    obs1.delete();

    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("load_busy", {31'd0, busy0}, 32'd1);
    check("load_hold", {31'd0, hold0}, 32'd1);
    check("load_flags_cleared", {30'd0, done0, err0}, 32'd0);
    @(posedge clk);
    #1;

    foreach (bytes[i]) begin
      if (maxgap > 0) gap($urandom_range(1, maxgap));
      send_byte(bytes[i]);
    end

    @(negedge clk);
    check("end_done", {31'd0, done0}, {31'd0, good});
    check("end_error", {31'd0, err0}, {31'd0, !good});
    check("end_hold", {31'd0, hold0}, {31'd0, !good});
    check("end_busy", {31'd0, busy0}, 32'd0);
    check("end_ready", {31'd0, bus0.rx_ready}, 32'd0);
    check("end_base254_state", {29'd0, done1, err1, hold1}, {29'd0, good, !good, !good});

    check("write_count_base0", obs0.size(), w.size());
    check("write_count_base254", obs1.size(), w.size());
    foreach (w[i]) begin
      if (i < obs0.size()) check("write_base0", {8'd0, obs0[i]}, {8'd0, 8'(i), w[i]});
      if (i < obs1.size()) check("write_base254", {8'd0, obs1[i]}, {8'd0, 8'(254 + i), w[i]});
    end
    @(posedge clk);
    #1;
  endtask

  logic [15:0] wq[$];

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hold", {31'd0, hold0}, 32'd1);
    check("rst_ready", {31'd0, bus0.rx_ready}, 32'd0);
    check("rst_we", {31'd0, bus0.mem_we}, 32'd0);
    check("rst_addr0", {24'd0, bus0.mem_addr}, 32'd0);
    check("rst_addr254", {24'd0, bus1.mem_addr}, 32'd254);
    check("rst_wdata", {16'd0, bus0.mem_wdata}, 32'd0);
    check("rst_flags", {29'd0, busy0, done0, err0}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Idle loader ignores stream bytes.
    rx_valid = 1'b1;
    rx_data  = 8'h5C;
    @(negedge clk);
    check("idle_ready", {31'd0, bus0.rx_ready}, 32'd0);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;

    wq = '{16'h1E1A, 16'h1F29};
    run_frame(wq, 8'h00, 0);
    wq = '{16'h1E1A, 16'h1F29};
    run_frame(wq, 8'h01, 0);
    wq = '{16'h1E1A, 16'h1F29};
    run_frame(wq, 8'h00, 0);

    wq.delete();
    run_frame(wq, 8'h00, 0);

    wq = '{16'h1E1A, 16'h1F29};
    run_frame(wq, 8'h00, 3);

    wq = '{16'h1111, 16'h2222, 16'h3333};
    run_frame(wq, 8'h00, 2);

    // Bytes beyond CSUM are never taken.
    rx_valid = 1'b1;
    rx_data  = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("extra_ready", {31'd0, bus0.rx_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("extra_no_write", obs0.size(), 32'd3);

    for (int f = 0; f < 10; f++) begin
      logic [7:0] flip;
      wq.delete();
      for (int i = 0; i < $urandom_range(0, 6); i++) wq.push_back(16'($urandom));
      flip = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      run_frame(wq, flip, 3);
    end

    wq.delete();
    for (int i = 0; i < 255; i++) wq.push_back(16'($urandom));
    run_frame(wq, 8'h00, 0);

    // Reset after the first write of a 3-word frame.
    obs0.delete();
    obs1.delete();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_byte(8'd3);
    send_byte(8'hA5);
    send_byte(8'h5A);
    @(negedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midrst_hold", {31'd0, hold0}, 32'd1);
    check("midrst_ready", {31'd0, bus0.rx_ready}, 32'd0);
    check("midrst_we", {31'd0, bus0.mem_we}, 32'd0);
    check("midrst_addr0", {24'd0, bus0.mem_addr}, 32'd0);
    check("midrst_addr254", {24'd0, bus1.mem_addr}, 32'd254);
    check("midrst_wdata", {16'd0, bus0.mem_wdata}, 32'd0);
    check("midrst_flags", {29'd0, busy0, done0, err0}, 32'd0);
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_data = 8'($urandom);
      @(negedge clk);
      check("midrst_no_accept", {31'd0, bus0.rx_ready}, 32'd0);
    end
    check("midrst_writes0", obs0.size(), 32'd1);
    check("midrst_writes254", obs1.size(), 32'd1);
    check("midrst_mem0", {16'd0, mem0[0]}, 32'h0000A55A);
    check("midrst_mem254", {16'd0, mem1[254]}, 32'h0000A55A);
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {30'd0, busy0, hold0}, 32'd1);
    @(posedge clk);
    #1;

    wq = '{16'hBEEF, 16'h0102, 16'hFFFF};
    run_frame(wq, 8'h00, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mcpu_program_loader.md
Name: mcpu_program_loader

Overview:
- Byte-stream program loader for the MCPU.
- Receives a framed image over a valid/ready byte interface and assembles big-endian 16-bit instruction words.
- Writes the words into the CPU RAM write port and holds the CPU in reset until a checksum-verified load completes.
- Sits between the host/UART byte source and the RAM write port; it is the writer side of the instruction memory that the MCPU fetches from.

Parameters:
- WORD_SIZE, 16, instruction/RAM word width; must equal 2 × 8.
- ADDR_SIZE, 8, RAM address width; addresses wrap modulo 2^ADDR_SIZE.
- LOAD_BASE, 0, RAM address of the first loaded word.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a load.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  RAM write enable, one cycle per word.
- mem_addr  output  ADDR_SIZE  RAM write address.
- mem_wdata  output  WORD_SIZE  RAM write data.
- cpu_hold  output  1  drive to the CPU reset; 1 holds the CPU.
- busy  output  1  load in progress.
- done  output  1  last load completed with a good checksum.
- error  output  1  last load failed its checksum.

Behaviour:
- Frame format: LEN byte N (0..255 words), then 2N payload bytes (high byte first per word), then CSUM byte.
- CSUM must equal the XOR of LEN and all payload bytes.
- Byte transfer occurs only on a rising edge with rx_valid && rx_ready. rx_data is ignored otherwise.
- rx_valid may drop at any time; the loader waits, with no timeout.
- Reset (reset=0, asynchronous):
  - state=IDLE; cpu_hold=1; rx_ready=0; mem_we=0.
  - mem_addr=LOAD_BASE; mem_wdata=0; busy=0; done=0; error=0.
  - Internal word counter and checksum accumulator cleared.
- States and transitions:
  - IDLE: rx_ready=0. start=1 → LEN; clear done/error; set busy.
  - LEN: rx_ready=1. On accept: N=byte; csum=byte; addr=LOAD_BASE. If N==0 → CSUM, else → HI.
  - HI: rx_ready=1. On accept: latch high byte; csum^=byte → LO.
  - LO: rx_ready=1. On accept: latch low byte; csum^=byte → WRITE.
  - WRITE: rx_ready=0; mem_we=1 for exactly this cycle; mem_wdata={hi,lo}; mem_addr=current address.
    - Next edge: address+1 (wraps 255→0); remaining count−1.
    - If remaining count was 1 → CSUM, else → HI.
  - CSUM: rx_ready=1. On accept:
    - byte==csum → DONE: done=1, cpu_hold=0, busy=0.
    - byte!=csum → ERR: error=1, cpu_hold stays 1, busy=0.
  - DONE/ERR: rx_ready=0. start=1 → LEN. Clears done/error, sets cpu_hold=1 and busy=1 on the same edge.
- cpu_hold is 1 in every state except DONE.
- mem_we is 1 only in WRITE; mem_addr/mem_wdata are don't-care otherwise but must hold their last values.
- Throughput: at least 3 cycles per word (HI, LO, WRITE). Minimum frame time: 2 + 3N cycles.
- start while busy is ignored.
- Words already written before an error or a mid-load reset remain in RAM. No further writes occur.
- Reset asserted mid-load aborts immediately with the reset values above.
- Payload longer than 2N bytes: the byte after the last word is taken as CSUM. Subsequent bytes are not accepted (rx_ready=0).

Test Plan:
- Good load: start, bytes 02,1E,1A,1F,29,30 → mem_we pulses with addr 0 data 16'h1E1A and addr 1 data 16'h1F29; then done=1, error=0, cpu_hold=0, busy=0.
- Bad checksum: same frame with CSUM 31 → both words written; error=1, done=0, cpu_hold=1; a later start plus the good frame gives done=1.
- Empty image: start, bytes 00,00 → no mem_we; done=1 two accepted bytes after start; cpu_hold=0.
- Backpressure/gaps: good frame with rx_valid low for 1–3 random cycles between bytes → identical writes and result; rx_ready=0 in every WRITE cycle and no byte lost or duplicated.
- Wrap: LOAD_BASE=254, frame of 3 words 0x1111,0x2222,0x3333 with correct CSUM → writes to addresses 254, 255, 0 in order.
- Reset mid-load: assert reset after the first WRITE of a 3-word frame → outputs at reset values immediately; mem[LOAD_BASE] retains its word; no further mem_we. A start pulse issued while busy in any load has no effect.
